// File: rtl/rgb_pattern_gen_if.sv
// Video source bundle for one LVDS link: run controls in, RGB and DE/HS/VS timing out.
// The generator connects through the master modport; the consumer uses the slave modport.
interface rgb_pattern_gen_if;
  logic        I_en;
  logic [1:0]  I_mode;
  logic [23:0] I_solid_rgb;
  logic [7:0]  O_R_data;
  logic [7:0]  O_G_data;
  logic [7:0]  O_B_data;
  logic        O_DE;
  logic        O_HS;
  logic        O_VS;
  logic        O_frame_start;
  logic [15:0] O_frame_cnt;

  modport master (
    input  I_en, I_mode, I_solid_rgb,
    output O_R_data, O_G_data, O_B_data, O_DE, O_HS, O_VS,
           O_frame_start, O_frame_cnt
  );

  modport slave (
    output I_en, I_mode, I_solid_rgb,
    input  O_R_data, O_G_data, O_B_data, O_DE, O_HS, O_VS,
           O_frame_start, O_frame_cnt
  );
endinterface

// File: rtl/rgb_pattern_gen.sv
// VESA-style timing plus a deterministic RGB test pattern for one LVDS link.
// Every output is registered one cycle after the counter state that produced it.
module rgb_pattern_gen #(
  parameter int H_ACTIVE = 1024,
  parameter int H_FP     = 24,
  parameter int H_SYNC   = 136,
  parameter int H_BP     = 160,
  parameter int V_ACTIVE = 768,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 29,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic              I_clk,
  input  logic              I_rst_n,
  rgb_pattern_gen_if.master vid
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_ACT_L  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG_L = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END_L = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] H_LAST_L = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] BAR_W_L  = HW'(H_ACTIVE / 8);
  localparam logic [HW-1:0] BAR_MAX  = HW'(7);
  localparam logic [VW-1:0] V_ACT_L  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG_L = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END_L = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_LAST_L = VW'(V_TOTAL - 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  // Fibonacci x^8+x^6+x^5+x^4+1, shifting right with feedback into the MSB.
  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[0] ^ s[4] ^ s[5] ^ s[6], s[7:1]};
  endfunction

  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    return 24'hFFFFFF;
      3'd1:    return 24'hFFFF00;
      3'd2:    return 24'h00FFFF;
      3'd3:    return 24'h00FF00;
      3'd4:    return 24'hFF00FF;
      3'd5:    return 24'hFF0000;
      3'd6:    return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  state_t        state_q, state_d;
  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic [1:0]    mode_q, mode_d;
  logic [23:0]   solid_q, solid_d;
  logic [15:0]   pix_idx_q, pix_idx_d;
  logic [7:0]    lfsr_q, lfsr_d;
  logic [23:0]   rgb_q, rgb_d;
  logic          de_q, de_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic          fs_q, fs_d;
  logic [15:0]   fcnt_q, fcnt_d;

  logic          emit;
  logic          boundary;
  logic          de_now;
  logic [1:0]    mode_cur;
  logic [23:0]   solid_cur;
  logic [15:0]   pix_cur;
  logic [7:0]    lfsr_cur;
  logic [HW-1:0] bar_raw;
  logic [2:0]    bar_sel;
  logic [23:0]   pattern;

  always_comb begin
    // A pixel is produced while running, and also in the IDLE cycle that sees
    // I_en, which is itself h=0,v=0 of the new frame.
    emit      = (state_q == S_RUN) || vid.I_en;
    boundary  = emit && (h_cnt_q == '0) && (v_cnt_q == '0);
    de_now    = emit && (h_cnt_q < H_ACT_L) && (v_cnt_q < V_ACT_L);

    mode_cur  = boundary ? vid.I_mode      : mode_q;
    solid_cur = boundary ? vid.I_solid_rgb : solid_q;
    pix_cur   = boundary ? 16'd0           : pix_idx_q;
    lfsr_cur  = boundary ? 8'hFF           : lfsr_q;

    bar_raw   = h_cnt_q / BAR_W_L;
    bar_sel   = (bar_raw > BAR_MAX) ? 3'd7 : bar_raw[2:0];

    case (mode_cur)
      2'd0:    pattern = {pix_cur[7:0], ~pix_cur[7:0], 8'(v_cnt_q)};
      2'd1:    pattern = {lfsr_cur, ~lfsr_cur, lfsr_cur};
      2'd2:    pattern = solid_cur;
      default: pattern = bar_colour(bar_sel);
    endcase

    rgb_d     = de_now ? pattern : 24'h000000;
    de_d      = de_now;
    hs_d      = (emit && (h_cnt_q >= HS_BEG_L) && (h_cnt_q < HS_END_L)) ? HS_POL : ~HS_POL;
    vs_d      = (emit && (v_cnt_q >= VS_BEG_L) && (v_cnt_q < VS_END_L)) ? VS_POL : ~VS_POL;
    fs_d      = boundary;
    fcnt_d    = boundary ? fcnt_q + 16'd1 : fcnt_q;
    mode_d    = mode_cur;
    solid_d   = solid_cur;
    pix_idx_d = de_now ? pix_cur + 16'd1 : pix_cur;
    lfsr_d    = de_now ? lfsr_next(lfsr_cur) : lfsr_cur;

    state_d   = S_IDLE;
    h_cnt_d   = '0;
    v_cnt_d   = '0;
    if (emit) begin
      state_d = S_RUN;
      if (h_cnt_q == H_LAST_L) begin
        if (v_cnt_q == V_LAST_L) begin
          // Enable is only honoured here, so a started frame always completes.
          if (!vid.I_en) state_d = S_IDLE;
        end else begin
          v_cnt_d = v_cnt_q + 1'b1;
        end
      end else begin
        h_cnt_d = h_cnt_q + 1'b1;
        v_cnt_d = v_cnt_q;
      end
    end
  end

  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      state_q   <= S_IDLE;
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      mode_q    <= 2'd0;
      solid_q   <= 24'h000000;
      pix_idx_q <= 16'd0;
      lfsr_q    <= 8'hFF;
      rgb_q     <= 24'h000000;
      de_q      <= 1'b0;
      hs_q      <= ~HS_POL;
      vs_q      <= ~VS_POL;
      fs_q      <= 1'b0;
      fcnt_q    <= 16'd0;
    end else begin
      state_q   <= state_d;
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      mode_q    <= mode_d;
      solid_q   <= solid_d;
      pix_idx_q <= pix_idx_d;
      lfsr_q    <= lfsr_d;
      rgb_q     <= rgb_d;
      de_q      <= de_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      fs_q      <= fs_d;
      fcnt_q    <= fcnt_d;
    end
  end

  assign vid.O_R_data      = rgb_q[23:16];
  assign vid.O_G_data      = rgb_q[15:8];
  assign vid.O_B_data      = rgb_q[7:0];
  assign vid.O_DE          = de_q;
  assign vid.O_HS          = hs_q;
  assign vid.O_VS          = vs_q;
  assign vid.O_frame_start = fs_q;
  assign vid.O_frame_cnt   = fcnt_q;

endmodule

// File: tb/tb_rgb_pattern_gen.sv
// Directed plus randomized bench for rgb_pattern_gen on a 14x7 (98-clock) frame,
// checked every cycle against a frame-position reference model.
module tb_rgb_pattern_gen;
  localparam int HA = 8, HFP = 2, HSY = 2, HBP = 2;
  localparam int VA = 4, VFP = 1, VSY = 1, VBP = 1;
  localparam int HT = HA + HFP + HSY + HBP;
  localparam int VT = VA + VFP + VSY + VBP;
  localparam int FT = HT * VT;
  localparam bit HS_POL = 1'b0;
  localparam bit VS_POL = 1'b0;

  logic clk = 1'b0;
  logic rst_n;

  rgb_pattern_gen_if vid();

  rgb_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .HS_POL(HS_POL), .VS_POL(VS_POL)
  ) dut (
    .I_clk  (clk),
    .I_rst_n(rst_n),
    .vid    (vid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: position within the frame and per-frame latches.
  bit          m_run;
  int          m_t;
  logic [15:0] m_fcnt;
  logic [1:0]  m_mode;
  logic [23:0] m_solid;
  logic [7:0]  lfsr_tab [FT];
  logic [23:0] bar_tab  [8];

  logic        cur_en;
  logic [1:0]  cur_mode;
  logic [23:0] cur_solid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r);
    logic [23:0] e_rgb;
    logic        e_de, e_hs, e_vs, e_fs;
    int          h, v, pix, bar;
    logic [7:0]  p8, v8;
    rst_n           = r;
    vid.I_en        = cur_en;
    vid.I_mode      = cur_mode;
    vid.I_solid_rgb = cur_solid;
    @(posedge clk);
    #1;
    e_rgb = 24'h0; e_de = 1'b0; e_hs = ~HS_POL; e_vs = ~VS_POL; e_fs = 1'b0;
    if (!r) begin
      m_run = 1'b0; m_t = 0; m_fcnt = 16'd0;
    end else if (m_run || cur_en) begin
      if (!m_run) begin m_run = 1'b1; m_t = 0; end
      if (m_t == 0) begin
        m_mode = cur_mode; m_solid = cur_solid; m_fcnt = m_fcnt + 16'd1; e_fs = 1'b1;
      end
      h = m_t % HT;
      v = m_t / HT;
      e_de = (h < HA) && (v < VA);
      e_hs = (h >= HA + HFP && h < HA + HFP + HSY) ? HS_POL : ~HS_POL;
      e_vs = (v >= VA + VFP && v < VA + VFP + VSY) ? VS_POL : ~VS_POL;
      if (e_de) begin
        pix = v * HA + h;
        p8  = pix[7:0];
        v8  = v[7:0];
        bar = h / (HA / 8);
        if (bar > 7) bar = 7;
        case (m_mode)
          2'd0:    e_rgb = {p8, ~p8, v8};
          2'd1:    e_rgb = {lfsr_tab[pix], ~lfsr_tab[pix], lfsr_tab[pix]};
          2'd2:    e_rgb = m_solid;
          default: e_rgb = bar_tab[bar];
        endcase
      end
      m_t++;
      if (m_t == FT) begin
        m_t = 0;
        if (!cur_en) m_run = 1'b0;
      end
    end
    chk("R",           32'(vid.O_R_data),      32'(e_rgb[23:16]));
    chk("G",           32'(vid.O_G_data),      32'(e_rgb[15:8]));
    chk("B",           32'(vid.O_B_data),      32'(e_rgb[7:0]));
    chk("DE",          32'(vid.O_DE),          32'(e_de));
    chk("HS",          32'(vid.O_HS),          32'(e_hs));
    chk("VS",          32'(vid.O_VS),          32'(e_vs));
    chk("frame_start", 32'(vid.O_frame_start), 32'(e_fs));
    chk("frame_cnt",   32'(vid.O_frame_cnt),   32'(m_fcnt));
  endtask

  // Advance (running, no reset) until the next edge will produce frame position t.
  task automatic wait_t(input int t);
    for (int i = 0; i < 2 * FT && m_t != t; i++) step(1'b1);
  endtask

  initial begin
    logic       b [FT + 8];
    logic [7:0] lfsr_lit [4];
    // PRBS bit stream for x^8+x^6+x^5+x^4+1 seeded all-ones; byte k is bits k+7..k.
    for (int n = 0; n < 8; n++) b[n] = 1'b1;
    for (int n = 0; n < FT; n++) b[n + 8] = b[n] ^ b[n + 4] ^ b[n + 5] ^ b[n + 6];
    for (int k = 0; k < FT; k++)
      for (int j = 0; j < 8; j++) lfsr_tab[k][j] = b[k + j];
    bar_tab[0] = 24'hFFFFFF; bar_tab[1] = 24'hFFFF00; bar_tab[2] = 24'h00FFFF;
    bar_tab[3] = 24'h00FF00; bar_tab[4] = 24'hFF00FF; bar_tab[5] = 24'hFF0000;
    bar_tab[6] = 24'h0000FF; bar_tab[7] = 24'h000000;
    lfsr_lit[0] = 8'hFF; lfsr_lit[1] = 8'h7F; lfsr_lit[2] = 8'h3F; lfsr_lit[3] = 8'h9F;

    m_run = 1'b0; m_t = 0; m_fcnt = 16'd0; m_mode = 2'd0; m_solid = 24'h0;
    cur_en = 1'b1; cur_mode = 2'd0; cur_solid = 24'h0;
    rst_n = 1'b0; vid.I_en = 1'b0; vid.I_mode = 2'd0; vid.I_solid_rgb = 24'h0;

    // Reset with enable already high, then ramp pattern for three frames.
    step(1'b0);
    step(1'b0);
    step(1'b1);
    chk("first_frame_start", 32'(vid.O_frame_start), 32'd1);
    chk("first_frame_cnt",   32'(vid.O_frame_cnt),   32'd1);
    repeat (3 * FT + 4) step(1'b1);

    // PRBS frame: first four red values, then two full frames.
    cur_mode = 2'd1;
    wait_t(0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1);
      chk("lfsr_seq", 32'(vid.O_R_data), 32'(lfsr_lit[i]));
    end
    repeat (2 * FT) step(1'b1);

    // Solid colour changed mid-frame only shows up at the next frame.
    cur_mode  = 2'd2;
    cur_solid = 24'h123456;
    wait_t(0);
    step(1'b1);
    chk("solid_first", 32'({vid.O_R_data, vid.O_G_data, vid.O_B_data}), 32'h123456);
    wait_t(50);
    cur_solid = 24'hABCDEF;
    wait_t(0);
    step(1'b1);
    chk("solid_next", 32'({vid.O_R_data, vid.O_G_data, vid.O_B_data}), 32'hABCDEF);

    // Colour bars.
    cur_mode = 2'd3;
    repeat (2 * FT) step(1'b1);

    // Enable dropped at v=2: frame completes, then idle, then restart.
    cur_mode = 2'd0;
    wait_t(2 * HT);
    cur_en = 1'b0;
    for (int i = 0; i < 2 * FT && m_run; i++) step(1'b1);
    repeat (10) step(1'b1);
    chk("idle_de", 32'(vid.O_DE), 32'd0);
    chk("idle_hs", 32'(vid.O_HS), 32'd1);
    chk("idle_vs", 32'(vid.O_VS), 32'd1);
    cur_en = 1'b1;
    step(1'b1);
    chk("restart_frame_start", 32'(vid.O_frame_start), 32'd1);

    // One-cycle reset at v=1,h=3.
    wait_t(HT + 3);
    step(1'b0);
    chk("midrst_frame_cnt", 32'(vid.O_frame_cnt), 32'd0);
    chk("midrst_de",        32'(vid.O_DE),        32'd0);
    step(1'b1);
    chk("midrst_restart",   32'(vid.O_frame_start), 32'd1);
    repeat (FT) step(1'b1);

    // Randomized controls: mode/colour churn, occasional enable toggles and resets.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 39) == 0)  cur_mode  = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0)  cur_solid = 24'($urandom);
      if ($urandom_range(0, 149) == 0) cur_en    = ~cur_en;
      step(($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
